// File: rtl/wb_vram_arbiter.sv
// Two-master Wishbone arbiter for the shared VRAM slave: display fetch (port 0) and CPU (port 1).
// Grants are held for the owner's whole cycle; a watchdog aborts transfers the slave never acks.
module wb_vram_arbiter #(
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wbs0_cyc_i,
    input  logic        wbs0_stb_i,
    input  logic        wbs0_we_i,
    input  logic [31:2] wbs0_addr_i,
    input  logic [2:0]  wbs0_cti_i,
    input  logic [1:0]  wbs0_bte_i,
    input  logic [3:0]  wbs0_sel_i,
    input  logic [31:0] wbs0_data_i,
    output logic [31:0] wbs0_data_o,
    output logic        wbs0_ack_o,
    output logic        wbs0_err_o,

    input  logic        wbs1_cyc_i,
    input  logic        wbs1_stb_i,
    input  logic        wbs1_we_i,
    input  logic [31:2] wbs1_addr_i,
    input  logic [2:0]  wbs1_cti_i,
    input  logic [1:0]  wbs1_bte_i,
    input  logic [3:0]  wbs1_sel_i,
    input  logic [31:0] wbs1_data_i,
    output logic [31:0] wbs1_data_o,
    output logic        wbs1_ack_o,
    output logic        wbs1_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:2] wbm_addr_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_data_o,
    input  logic [31:0] wbm_data_i,
    input  logic        wbm_ack_i,

    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] WDT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT);

    state_t                   state_q, state_d;
    logic                     last_q, last_d;
    logic                     hold0_q, hold0_d;
    logic                     hold1_q, hold1_d;
    logic                     timeout_q, timeout_d;
    logic [TIMEOUT_WIDTH-1:0] wdt_q, wdt_d;

    logic req0, req1;
    logic owner_cyc;
    logic wdt_expired;
    logic abort;

    // An aborted master stays ineligible until it ends its own cycle.
    assign req0 = wbs0_cyc_i & ~hold0_q;
    assign req1 = wbs1_cyc_i & ~hold1_q;

    assign wbs0_data_o = wbm_data_i;
    assign wbs1_data_o = wbm_data_i;
    assign timeout_o   = timeout_q;

    always_comb begin
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_addr_o = '0;
        wbm_cti_o  = '0;
        wbm_bte_o  = '0;
        wbm_sel_o  = '0;
        wbm_data_o = '0;
        wbs0_ack_o = 1'b0;
        wbs1_ack_o = 1'b0;
        owner_cyc  = 1'b0;
        case (state_q)
            GNT0: begin
                wbm_cyc_o  = wbs0_cyc_i;
                wbm_stb_o  = wbs0_stb_i;
                wbm_we_o   = wbs0_we_i;
                wbm_addr_o = wbs0_addr_i;
                wbm_cti_o  = wbs0_cti_i;
                wbm_bte_o  = wbs0_bte_i;
                wbm_sel_o  = wbs0_sel_i;
                wbm_data_o = wbs0_data_i;
                wbs0_ack_o = wbm_ack_i;
                owner_cyc  = wbs0_cyc_i;
            end
            GNT1: begin
                wbm_cyc_o  = wbs1_cyc_i;
                wbm_stb_o  = wbs1_stb_i;
                wbm_we_o   = wbs1_we_i;
                wbm_addr_o = wbs1_addr_i;
                wbm_cti_o  = wbs1_cti_i;
                wbm_bte_o  = wbs1_bte_i;
                wbm_sel_o  = wbs1_sel_i;
                wbm_data_o = wbs1_data_i;
                wbs1_ack_o = wbm_ack_i;
                owner_cyc  = wbs1_cyc_i;
            end
            default: ;
        endcase
    end

    // A same-cycle ack beats the watchdog.
    assign wdt_expired = (wdt_q == WDT_LIMIT);
    assign abort       = (state_q != IDLE) & owner_cyc & wdt_expired & ~wbm_ack_i;
    assign wbs0_err_o  = abort & (state_q == GNT0);
    assign wbs1_err_o  = abort & (state_q == GNT1);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold0_d   = hold0_q & wbs0_cyc_i;
        hold1_d   = hold1_q & wbs1_cyc_i;
        timeout_d = timeout_q | abort;
        wdt_d     = '0;

        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!wbs0_cyc_i) begin
                    state_d = IDLE;
                end else if (abort) begin
                    state_d = IDLE;
                    hold0_d = 1'b1;
                end
            end
            GNT1: begin
                if (!wbs1_cyc_i) begin
                    state_d = IDLE;
                end else if (abort) begin
                    state_d = IDLE;
                    hold1_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter saturates at the limit; the abort always fires there first.
        if ((state_q != IDLE) && (state_d != IDLE) && !wbm_ack_i) begin
            if (wbm_stb_o && !wdt_expired) begin
                wdt_d = wdt_q + 1'b1;
            end else begin
                wdt_d = wdt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold0_q   <= 1'b0;
            hold1_q   <= 1'b0;
            timeout_q <= 1'b0;
            wdt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold0_q   <= hold0_d;
            hold1_q   <= hold1_d;
            timeout_q <= timeout_d;
            wdt_q     <= wdt_d;
        end
    end

endmodule

// File: tb/tb_wb_vram_arbiter.sv
// Bench for wb_vram_arbiter: vector table for arbitration/routing plus sequences for
// bursts, watchdog abort, ack/timeout collision and mid-burst reset; acks go through a scoreboard.
module tb_wb_vram_arbiter;
    localparam int TIMEOUT = 4;

    localparam logic [31:2] A0  = 30'h0000_0100;
    localparam logic [31:2] A1  = 30'h0000_0200;
    localparam logic [31:0] WD0 = 32'h0A0A_0A0A;
    localparam logic [31:0] WD1 = 32'h1B1B_1B1B;

    logic        clk;
    logic        rst;
    logic        wbs0_cyc_i, wbs0_stb_i, wbs0_we_i;
    logic [31:2] wbs0_addr_i;
    logic [2:0]  wbs0_cti_i;
    logic [1:0]  wbs0_bte_i;
    logic [3:0]  wbs0_sel_i;
    logic [31:0] wbs0_data_i, wbs0_data_o;
    logic        wbs0_ack_o, wbs0_err_o;
    logic        wbs1_cyc_i, wbs1_stb_i, wbs1_we_i;
    logic [31:2] wbs1_addr_i;
    logic [2:0]  wbs1_cti_i;
    logic [1:0]  wbs1_bte_i;
    logic [3:0]  wbs1_sel_i;
    logic [31:0] wbs1_data_i, wbs1_data_o;
    logic        wbs1_ack_o, wbs1_err_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:2] wbm_addr_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_data_o, wbm_data_i;
    logic        wbm_ack_i;
    logic        timeout_o;

    wb_vram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .wbs0_cyc_i(wbs0_cyc_i), .wbs0_stb_i(wbs0_stb_i), .wbs0_we_i(wbs0_we_i),
        .wbs0_addr_i(wbs0_addr_i), .wbs0_cti_i(wbs0_cti_i), .wbs0_bte_i(wbs0_bte_i),
        .wbs0_sel_i(wbs0_sel_i), .wbs0_data_i(wbs0_data_i), .wbs0_data_o(wbs0_data_o),
        .wbs0_ack_o(wbs0_ack_o), .wbs0_err_o(wbs0_err_o),
        .wbs1_cyc_i(wbs1_cyc_i), .wbs1_stb_i(wbs1_stb_i), .wbs1_we_i(wbs1_we_i),
        .wbs1_addr_i(wbs1_addr_i), .wbs1_cti_i(wbs1_cti_i), .wbs1_bte_i(wbs1_bte_i),
        .wbs1_sel_i(wbs1_sel_i), .wbs1_data_i(wbs1_data_i), .wbs1_data_o(wbs1_data_o),
        .wbs1_ack_o(wbs1_ack_o), .wbs1_err_o(wbs1_err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_addr_o(wbm_addr_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_sel_o(wbm_sel_o), .wbm_data_o(wbm_data_o), .wbm_data_i(wbm_data_i),
        .wbm_ack_i(wbm_ack_i), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          port;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    // e_own: 0 = nobody owns the bus, 1 = master 0, 2 = master 1
    typedef struct {
        bit          rst;
        bit          c0;
        bit          c1;
        bit          ack;
        logic [31:0] d;
        bit          e_cyc;
        int          e_own;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int port, input logic [31:0] d);
        sb_t e;
        e.port = port;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_m(input bit c0, input bit c1);
        wbs0_cyc_i = c0;
        wbs0_stb_i = c0;
        wbs1_cyc_i = c1;
        wbs1_stb_i = c1;
    endtask

    task automatic slave(input bit a, input logic [31:0] d);
        wbm_ack_i  = a;
        wbm_data_i = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_m(0, 0);
        slave(0, 32'h0);
        adv();
        adv();
        rst = 1'b0;
    endtask

    // Every ack seen by a master must match the oldest expected {port, data} of this cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wbs0_ack_o === 1'b1 || wbs1_ack_o === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected_ack: ack0=%b ack1=%b, expected no ack", wbs0_ack_o, wbs1_ack_o);
                end else begin
                    sb_t e;
                    int  port;
                    logic [31:0] d;
                    e = sb.pop_front();
                    port = wbs1_ack_o ? 1 : 0;
                    d = wbs1_ack_o ? wbs1_data_o : wbs0_data_o;
                    if ((wbs0_ack_o && wbs1_ack_o) || port != e.port || d !== e.data) begin
                        n_errors++;
                        $display("FAIL sb_ack: got ack0=%b ack1=%b data=%h, expected port %0d data=%h",
                                 wbs0_ack_o, wbs1_ack_o, d, e.port, e.data);
                    end
                end
            end else if (sb.size() != 0) begin
                sb_t e;
                e = sb.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL sb_missing_ack: got no ack, expected port %0d data=%h", e.port, e.data);
            end
        end
    end

    vec_t tv[22];

    initial begin
        tv[0]  = '{0, 1, 0, 0, 32'h0,         0, 0};
        tv[1]  = '{0, 1, 0, 0, 32'h0,         1, 1};
        tv[2]  = '{0, 1, 0, 0, 32'h0,         1, 1};
        tv[3]  = '{0, 1, 0, 1, 32'hDEADBEEF,  1, 1};
        tv[4]  = '{0, 0, 0, 0, 32'h0,         0, 1};
        tv[5]  = '{0, 0, 0, 0, 32'h0,         0, 0};
        tv[6]  = '{1, 1, 1, 0, 32'h0,         0, 0};
        tv[7]  = '{0, 1, 1, 0, 32'h0,         0, 0};
        tv[8]  = '{0, 1, 1, 0, 32'h0,         1, 1};
        tv[9]  = '{0, 1, 1, 1, 32'h11111111,  1, 1};
        tv[10] = '{0, 0, 1, 0, 32'h0,         0, 1};
        tv[11] = '{0, 0, 1, 1, 32'h55555555,  0, 0};
        tv[12] = '{0, 1, 1, 0, 32'h0,         1, 2};
        tv[13] = '{0, 1, 1, 1, 32'h22222222,  1, 2};
        tv[14] = '{0, 1, 0, 0, 32'h0,         0, 2};
        tv[15] = '{0, 1, 1, 0, 32'h0,         0, 0};
        tv[16] = '{0, 1, 1, 0, 32'h0,         1, 1};
        tv[17] = '{0, 0, 1, 0, 32'h0,         0, 1};
        tv[18] = '{0, 0, 1, 0, 32'h0,         0, 0};
        tv[19] = '{0, 0, 1, 0, 32'h0,         1, 2};
        tv[20] = '{0, 0, 0, 0, 32'h0,         0, 2};
        tv[21] = '{0, 0, 0, 0, 32'h0,         0, 0};

        wbs0_we_i = 1'b0; wbs0_addr_i = A0; wbs0_cti_i = 3'b000; wbs0_bte_i = 2'b00;
        wbs0_sel_i = 4'hF; wbs0_data_i = WD0;
        wbs1_we_i = 1'b1; wbs1_addr_i = A1; wbs1_cti_i = 3'b111; wbs1_bte_i = 2'b01;
        wbs1_sel_i = 4'h3; wbs1_data_i = WD1;

        do_reset();
        mon_en = 1'b1;

        // Reset state
        mid();
        chk("rst_wbm_cyc", wbm_cyc_o, 0);
        chk("rst_wbm_addr", wbm_addr_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_err", {wbs0_err_o, wbs1_err_o}, 0);
        adv();

        // Vector table: single read, contention alternation, dead cycles
        for (int i = 0; i < 22; i++) begin
            logic [31:2] ea;
            logic [31:0] ed;
            rst = tv[i].rst;
            set_m(tv[i].c0, tv[i].c1);
            slave(tv[i].ack, tv[i].d);
            if (tv[i].ack && tv[i].e_own != 0) push(tv[i].e_own - 1, tv[i].d);
            ea = (tv[i].e_own == 1) ? A0 : (tv[i].e_own == 2) ? A1 : 30'h0;
            ed = (tv[i].e_own == 1) ? WD0 : (tv[i].e_own == 2) ? WD1 : 32'h0;
            mid();
            chk($sformatf("v%0d_cyc", i), wbm_cyc_o, tv[i].e_cyc);
            chk($sformatf("v%0d_stb", i), wbm_stb_o, tv[i].e_cyc);
            chk($sformatf("v%0d_addr", i), wbm_addr_o, ea);
            chk($sformatf("v%0d_we", i), wbm_we_o, (tv[i].e_own == 2));
            chk($sformatf("v%0d_wdata", i), wbm_data_o, ed);
            chk($sformatf("v%0d_sel", i), wbm_sel_o,
                (tv[i].e_own == 1) ? 4'hF : (tv[i].e_own == 2) ? 4'h3 : 4'h0);
            chk($sformatf("v%0d_err", i), {wbs0_err_o, wbs1_err_o}, 0);
            adv();
        end
        rst = 1'b0;

        // Atomic 8-beat burst on master 0 while master 1 keeps requesting
        do_reset();
        set_m(1, 1);
        wbs0_cti_i = 3'b010;
        mid();
        chk("burst_idle_cyc", wbm_cyc_o, 0);
        adv();
        for (int i = 0; i < 8; i++) begin
            wbs0_addr_i = A0 + 30'(i);
            wbs0_cti_i  = (i == 7) ? 3'b111 : 3'b010;
            slave(1, 32'hB000_0000 + 32'(i));
            push(0, 32'hB000_0000 + 32'(i));
            mid();
            chk($sformatf("burst%0d_addr", i), wbm_addr_o, A0 + 30'(i));
            chk($sformatf("burst%0d_cti", i), wbm_cti_o, (i == 7) ? 3'b111 : 3'b010);
            adv();
        end
        set_m(0, 1);
        wbs0_addr_i = A0;
        wbs0_cti_i  = 3'b000;
        slave(0, 32'h0);
        mid();
        chk("burst_rel_cyc", wbm_cyc_o, 0);
        adv();
        mid();
        chk("burst_dead_addr", wbm_addr_o, 0);
        adv();
        mid();
        chk("burst_gnt1_addr", wbm_addr_o, A1);
        chk("burst_gnt1_cyc", wbm_cyc_o, 1);
        adv();
        set_m(0, 0);
        mid(); adv();
        mid(); adv();

        // Watchdog abort on master 1, master 0 served while master 1 is held off
        do_reset();
        set_m(0, 1);
        mid();
        chk("to_idle_cyc", wbm_cyc_o, 0);
        adv();
        for (int i = 0; i <= TIMEOUT; i++) begin
            mid();
            chk($sformatf("to_stall%0d_err1", i), wbs1_err_o, (i == TIMEOUT));
            chk($sformatf("to_stall%0d_err0", i), wbs0_err_o, 0);
            chk($sformatf("to_stall%0d_cyc", i), wbm_cyc_o, 1);
            chk($sformatf("to_stall%0d_flag", i), timeout_o, 0);
            adv();
        end
        set_m(1, 1);
        mid();
        chk("to_after_cyc", wbm_cyc_o, 0);
        chk("to_after_err1", wbs1_err_o, 0);
        chk("to_after_flag", timeout_o, 1);
        adv();
        slave(1, 32'hC0C0_C0C0);
        push(0, 32'hC0C0_C0C0);
        mid();
        chk("to_m0_addr", wbm_addr_o, A0);
        adv();
        set_m(0, 1);
        slave(0, 32'h0);
        mid(); adv();
        for (int i = 0; i < 2; i++) begin
            mid();
            chk($sformatf("to_hold%0d_cyc", i), wbm_cyc_o, 0);
            chk($sformatf("to_hold%0d_flag", i), timeout_o, 1);
            adv();
        end
        set_m(0, 0);
        mid(); adv();
        set_m(0, 1);
        mid();
        chk("to_rereq_idle", wbm_cyc_o, 0);
        adv();
        mid();
        chk("to_regrant_cyc", wbm_cyc_o, 1);
        chk("to_regrant_addr", wbm_addr_o, A1);
        adv();
        set_m(0, 0);
        mid(); adv();
        mid(); adv();

        // Ack lands in the cycle the watchdog would fire
        do_reset();
        mid();
        chk("col_rst_flag", timeout_o, 0);
        adv();
        set_m(0, 1);
        mid(); adv();
        for (int i = 0; i <= TIMEOUT; i++) begin
            slave(i == TIMEOUT, 32'hA5A5_0000 + 32'(i));
            if (i == TIMEOUT) push(1, 32'hA5A5_0000 + 32'(i));
            mid();
            chk($sformatf("col%0d_err1", i), wbs1_err_o, 0);
            adv();
        end
        slave(0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk($sformatf("col_post%0d_err1", i), wbs1_err_o, 0);
            chk($sformatf("col_post%0d_cyc", i), wbm_cyc_o, 1);
            adv();
        end
        set_m(0, 0);
        mid();
        chk("col_flag_a", timeout_o, 0);
        adv();
        mid();
        chk("col_flag_b", timeout_o, 0);
        adv();

        // Reset during beat 3 of a master 0 burst
        do_reset();
        set_m(1, 1);
        wbs0_cti_i = 3'b010;
        mid(); adv();
        for (int b = 1; b <= 2; b++) begin
            slave(1, 32'hD000_0000 + 32'(b));
            push(0, 32'hD000_0000 + 32'(b));
            mid(); adv();
        end
        rst = 1'b1;
        slave(1, 32'hD000_0003);
        push(0, 32'hD000_0003);
        mid();
        chk("mrst_beat3_cyc", wbm_cyc_o, 1);
        adv();
        rst = 1'b0;
        slave(1, 32'h0000_0077);
        mid();
        chk("mrst_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
        chk("mrst_addr", wbm_addr_o, 0);
        chk("mrst_cti_bte_sel", {wbm_cti_o, wbm_bte_o, wbm_sel_o}, 0);
        chk("mrst_wdata", wbm_data_o, 0);
        chk("mrst_acks", {wbs0_ack_o, wbs1_ack_o}, 0);
        chk("mrst_errs", {wbs0_err_o, wbs1_err_o}, 0);
        adv();
        slave(0, 32'h0);
        wbs0_cti_i = 3'b000;
        mid();
        chk("mrst_regrant_cyc", wbm_cyc_o, 1);
        chk("mrst_regrant_addr", wbm_addr_o, A0);
        adv();
        set_m(0, 0);
        mid(); adv();
        mid(); adv();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
